// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage F/D/E/M/W datapath.
// Produces forwarding selects, stalls/flushes, a memory-wait pipeline hold and perf counters.
module hazard_ctrl #(
   parameter int CNT_W       = 16,
   parameter int TO_W        = 8,
   parameter int MEM_TIMEOUT = 200
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Match_1E_M,
   input  logic             Match_1E_W,
   input  logic             Match_2E_M,
   input  logic             Match_2E_W,
   input  logic             Match_12D_E,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemtoRegE,
   input  logic             PCSr_D,
   input  logic             PCSr_E,
   input  logic             PCSr_M,
   input  logic             PCSr_W,
   input  logic             BTaken_E,
   input  logic             MemAccessM,
   input  logic             DMemReady,
   output logic [1:0]       Forward_AE,
   output logic [1:0]       Forward_BE,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_Flush,
   output logic             E_flush,
   output logic             PipeHold,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_cycles
);

   typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(MEM_TIMEOUT);

   state_t            r_state, w_state_nxt;
   logic [TO_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;
   logic              r_mem_timeout, w_mem_timeout_nxt;
   logic [CNT_W-1:0]  r_stall_cycles, r_flush_cycles;
   logic              w_ldr_stall, w_pc_pend, w_mem_stuck, w_hold;

   // M stage holds the younger result, so it wins over W.
   always_comb begin
      Forward_AE = 2'b00;
      Forward_BE = 2'b00;
      if (Match_1E_M && RegWriteM)      Forward_AE = 2'b10;
      else if (Match_1E_W && RegWriteW) Forward_AE = 2'b01;
      if (Match_2E_M && RegWriteM)      Forward_BE = 2'b10;
      else if (Match_2E_W && RegWriteW) Forward_BE = 2'b01;
   end

   assign w_ldr_stall = Match_12D_E & MemtoRegE & RegWriteE;
   assign w_pc_pend   = PCSr_D | PCSr_E | PCSr_M;
   assign w_mem_stuck = MemAccessM & ~DMemReady;
   assign w_hold      = w_mem_stuck | (r_state == ERR);

   // A hold freezes everything, so flushes (and any branch redirect) wait for it to clear.
   always_comb begin
      F_stall  = w_ldr_stall | w_pc_pend;
      D_stall  = w_ldr_stall;
      D_Flush  = w_pc_pend | PCSr_W | BTaken_E;
      E_flush  = w_ldr_stall | BTaken_E;
      PipeHold = w_hold;
      if (w_hold) begin
         F_stall = 1'b1;
         D_stall = 1'b1;
         D_Flush = 1'b0;
         E_flush = 1'b0;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_wait_cnt_nxt    = r_wait_cnt;
      w_mem_timeout_nxt = r_mem_timeout;
      case (r_state)
         RUN: begin
            if (w_mem_stuck) begin
               w_state_nxt    = WAIT;
               w_wait_cnt_nxt = TO_W'(1);
            end
         end
         WAIT: begin
            if (!MemAccessM || DMemReady) begin
               w_state_nxt    = RUN;
               w_wait_cnt_nxt = '0;
            end else if (r_wait_cnt == TO_LIM) begin
               w_state_nxt       = ERR;
               w_mem_timeout_nxt = 1'b1;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + TO_W'(1);
            end
         end
         ERR: begin
            w_mem_timeout_nxt = 1'b1;
         end
         default: begin
            w_state_nxt    = RUN;
            w_wait_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= RUN;
         r_wait_cnt     <= '0;
         r_mem_timeout  <= 1'b0;
         r_stall_cycles <= '0;
         r_flush_cycles <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_wait_cnt    <= w_wait_cnt_nxt;
         r_mem_timeout <= w_mem_timeout_nxt;
         if (F_stall && (r_stall_cycles != CNT_MAX))
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         if ((D_Flush || E_flush) && (r_flush_cycles != CNT_MAX))
            r_flush_cycles <= r_flush_cycles + CNT_W'(1);
      end
   end

   assign mem_timeout  = r_mem_timeout;
   assign stall_cycles = r_stall_cycles;
   assign flush_cycles = r_flush_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, hand-written multi-cycle sequences and a random run,
// two instances (short timeout / narrow counters) checked every cycle against a rule model.
module tb_hazard_ctrl;

  logic clk, reset;
  logic Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic PCSr_D, PCSr_E, PCSr_M, PCSr_W, BTaken_E, MemAccessM, DMemReady;

  logic [1:0] fa [2];
  logic [1:0] fb [2];
  logic fs [2], ds [2], df [2], ef [2], ph [2], mto [2];
  logic [15:0] st0, fl0;
  logic [2:0]  st1, fl1;

  int total = 0;
  int bad = 0;

  hazard_ctrl #(.CNT_W(16), .TO_W(8), .MEM_TIMEOUT(4)) u_dut (
    .clk(clk), .reset(reset),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W), .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
    .Match_12D_E(Match_12D_E), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSr_D(PCSr_D), .PCSr_E(PCSr_E), .PCSr_M(PCSr_M), .PCSr_W(PCSr_W),
    .BTaken_E(BTaken_E), .MemAccessM(MemAccessM), .DMemReady(DMemReady),
    .Forward_AE(fa[0]), .Forward_BE(fb[0]), .F_stall(fs[0]), .D_stall(ds[0]),
    .D_Flush(df[0]), .E_flush(ef[0]), .PipeHold(ph[0]), .mem_timeout(mto[0]),
    .stall_cycles(st0), .flush_cycles(fl0)
  );

  hazard_ctrl #(.CNT_W(3), .TO_W(8), .MEM_TIMEOUT(200)) u_sat (
    .clk(clk), .reset(reset),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W), .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
    .Match_12D_E(Match_12D_E), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSr_D(PCSr_D), .PCSr_E(PCSr_E), .PCSr_M(PCSr_M), .PCSr_W(PCSr_W),
    .BTaken_E(BTaken_E), .MemAccessM(MemAccessM), .DMemReady(DMemReady),
    .Forward_AE(fa[1]), .Forward_BE(fb[1]), .F_stall(fs[1]), .D_stall(ds[1]),
    .D_Flush(df[1]), .E_flush(ef[1]), .PipeHold(ph[1]), .mem_timeout(mto[1]),
    .stall_cycles(st1), .flush_cycles(fl1)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_limit [2] = '{4, 200};
  int m_max   [2] = '{65535, 7};
  int m_stall [2];
  int m_flush [2];
  int m_run   [2];   // consecutive cycles with a not-ready memory access
  bit m_err   [2];

  logic [1:0] e_fa, e_fb;
  logic e_fs [2], e_ds [2], e_df [2], e_ef [2], e_ph [2];

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_stall[i] = 0; m_flush[i] = 0; m_run[i] = 0; m_err[i] = 1'b0;
    end
  endtask

  task automatic model_eval();
    logic ldr, pcp, stuck, hold;
    e_fa = (Match_1E_M && RegWriteM) ? 2'd2 : (Match_1E_W && RegWriteW) ? 2'd1 : 2'd0;
    e_fb = (Match_2E_M && RegWriteM) ? 2'd2 : (Match_2E_W && RegWriteW) ? 2'd1 : 2'd0;
    ldr   = Match_12D_E & MemtoRegE & RegWriteE;
    pcp   = PCSr_D | PCSr_E | PCSr_M;
    stuck = MemAccessM & ~DMemReady;
    for (int i = 0; i < 2; i++) begin
      hold    = stuck | m_err[i];
      e_ph[i] = hold;
      e_fs[i] = hold | ldr | pcp;
      e_ds[i] = hold | ldr;
      e_df[i] = hold ? 1'b0 : (pcp | PCSr_W | BTaken_E);
      e_ef[i] = hold ? 1'b0 : (ldr | BTaken_E);
    end
  endtask

  task automatic model_update();
    model_eval();
    if (!reset) begin
      model_clear();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (e_fs[i] && m_stall[i] < m_max[i]) m_stall[i]++;
        if ((e_df[i] || e_ef[i]) && m_flush[i] < m_max[i]) m_flush[i]++;
        if (!m_err[i]) begin
          m_run[i] = (MemAccessM && !DMemReady) ? m_run[i] + 1 : 0;
          if (m_run[i] == m_limit[i] + 1) m_err[i] = 1'b1;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    model_eval();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.Forward_AE", i), 32'(fa[i]), 32'(e_fa));
      chk($sformatf("u%0d.Forward_BE", i), 32'(fb[i]), 32'(e_fb));
      chk($sformatf("u%0d.F_stall", i), 32'(fs[i]), 32'(e_fs[i]));
      chk($sformatf("u%0d.D_stall", i), 32'(ds[i]), 32'(e_ds[i]));
      chk($sformatf("u%0d.D_Flush", i), 32'(df[i]), 32'(e_df[i]));
      chk($sformatf("u%0d.E_flush", i), 32'(ef[i]), 32'(e_ef[i]));
      chk($sformatf("u%0d.PipeHold", i), 32'(ph[i]), 32'(e_ph[i]));
      chk($sformatf("u%0d.mem_timeout", i), 32'(mto[i]), 32'(m_err[i]));
    end
    chk("u0.stall_cycles", 32'(st0), 32'(m_stall[0]));
    chk("u0.flush_cycles", 32'(fl0), 32'(m_flush[0]));
    chk("u1.stall_cycles", 32'(st1), 32'(m_stall[1]));
    chk("u1.flush_cycles", 32'(fl1), 32'(m_flush[1]));
  endtask

  // ---------------- driver tasks ----------------
  // bit order: m1em m1ew m2em m2ew | m12de rwe rwm rww | mtre pd pe pm | pw bt ma rdy
  task automatic apply(input logic [15:0] v);
    {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W,
     Match_12D_E, RegWriteE, RegWriteM, RegWriteW,
     MemtoRegE, PCSr_D, PCSr_E, PCSr_M,
     PCSr_W, BTaken_E, MemAccessM, DMemReady} = v;
  endtask

  task automatic to_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic to_edge();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    apply(16'h0);
    reset = 1'b0;
    to_neg();
    to_edge();
    reset = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [15:0] in;
    logic [8:0]  exp;   // {fa[1:0], fb[1:0], F_stall, D_stall, D_Flush, E_flush, PipeHold}
  } vec_t;

  vec_t vecs [15];
  localparam logic [15:0] LDR_USE = 16'b0000_1100_1000_0000;

  initial begin
    vecs[0]  = '{16'b1100_0011_0000_0000, 9'b10_00_00000};
    vecs[1]  = '{16'b1100_0001_0000_0000, 9'b01_00_00000};
    vecs[2]  = '{16'b1100_0000_0000_0000, 9'b00_00_00000};
    vecs[3]  = '{16'b0011_0011_0000_0000, 9'b00_10_00000};
    vecs[4]  = '{16'b0011_0001_0000_0000, 9'b00_01_00000};
    vecs[5]  = '{16'b0011_0000_0000_0000, 9'b00_00_00000};
    vecs[6]  = '{16'b0100_0011_0000_0000, 9'b01_00_00000};
    vecs[7]  = '{LDR_USE,                 9'b00_00_11010};
    vecs[8]  = '{16'b0000_1000_1000_0000, 9'b00_00_00000};
    vecs[9]  = '{16'b0000_0000_0000_0100, 9'b00_00_00110};
    vecs[10] = '{16'b0000_0000_0100_0000, 9'b00_00_10100};
    vecs[11] = '{16'b0000_0000_0000_1000, 9'b00_00_00100};
    vecs[12] = '{16'b0000_0000_0001_0000, 9'b00_00_10100};
    vecs[13] = '{16'b1000_1110_1000_0110, 9'b10_00_11001};
    vecs[14] = '{16'b0000_0000_0000_0111, 9'b00_00_00110};

    // reset: let the first edge clear the registers before anything is compared
    reset = 1'b0;
    apply(16'h0);
    model_clear();
    @(posedge clk); #1;
    model_clear();
    to_neg();
    to_edge();
    reset = 1'b1;
    to_neg();
    chk("reset.stall_cycles", 32'(st0), 32'd0);
    chk("reset.flush_cycles", 32'(fl0), 32'd0);
    chk("reset.mem_timeout", 32'(mto[0]), 32'd0);
    chk("reset.PipeHold", 32'(ph[0]), 32'd0);
    to_edge();

    // table
    for (int k = 0; k < 15; k++) begin
      apply(vecs[k].in);
      to_neg();
      chk($sformatf("vec%0d.outs", k),
          {23'd0, fa[0], fb[0], fs[0], ds[0], df[0], ef[0], ph[0]}, {23'd0, vecs[k].exp});
      to_edge();
    end

    // load-use for one cycle, then counters
    do_reset();
    apply(LDR_USE);
    to_neg();
    chk("ldr.F_D_E", {29'd0, fs[0], ds[0], ef[0]}, 32'd7);
    chk("ldr.D_Flush", 32'(df[0]), 32'd0);
    to_edge();
    apply(16'h0);
    to_neg();
    chk("ldr.stall_cycles", 32'(st0), 32'd1);
    chk("ldr.flush_cycles", 32'(fl0), 32'd1);
    to_edge();

    // memory wait of 3 cycles with a taken branch that must not flush
    do_reset();
    apply(16'b0000_0000_0000_0110);
    for (int k = 0; k < 3; k++) begin
      to_neg();
      chk($sformatf("wait%0d.PipeHold", k), 32'(ph[0]), 32'd1);
      chk($sformatf("wait%0d.D_Flush", k), 32'(df[0]), 32'd0);
      to_edge();
    end
    apply(16'b0000_0000_0000_0011);
    to_neg();
    chk("ready.PipeHold", 32'(ph[0]), 32'd0);
    to_edge();
    apply(16'h0);
    to_neg();
    chk("wait.stall_cycles", 32'(st0), 32'd3);
    to_edge();
    // back-to-back: a fresh wait restarts its count, so 4 more stuck cycles do not trip
    apply(16'b0000_0000_0000_0010);
    for (int k = 0; k < 4; k++) begin to_neg(); to_edge(); end
    apply(16'h0);
    to_neg();
    chk("rewait.mem_timeout", 32'(mto[0]), 32'd0);
    to_edge();

    // timeout (u_dut has a limit of 4)
    do_reset();
    apply(16'b0000_0000_0000_0010);
    for (int k = 0; k < 4; k++) begin to_neg(); to_edge(); end
    to_neg();
    chk("to.before5", 32'(mto[0]), 32'd0);
    to_edge();
    to_neg();
    chk("to.after5", 32'(mto[0]), 32'd1);
    chk("to.u1_clear", 32'(mto[1]), 32'd0);
    to_edge();
    apply(16'h0);
    to_neg();
    chk("to.hold_sticky", 32'(ph[0]), 32'd1);
    to_edge();
    reset = 1'b0;
    to_neg();
    to_edge();
    reset = 1'b1;
    to_neg();
    chk("to.rst.mem_timeout", 32'(mto[0]), 32'd0);
    chk("to.rst.stall", 32'(st0), 32'd0);
    chk("to.rst.PipeHold", 32'(ph[0]), 32'd0);
    to_edge();

    // saturation on the 3-bit instance
    do_reset();
    apply(LDR_USE);
    for (int k = 0; k < 10; k++) begin to_neg(); to_edge(); end
    apply(16'h0);
    to_neg();
    chk("sat.u1_stall", 32'(st1), 32'd7);
    chk("sat.u0_stall", 32'(st0), 32'd10);
    to_edge();

    // random run with occasional resets and varying memory readiness
    begin
      int rdy_bias;
      logic [15:0] v;
      rdy_bias = 4;
      for (int n = 0; n < 2000; n++) begin
        if (n % 200 == 0) rdy_bias = $urandom_range(1, 7);
        if ($urandom_range(0, 39) == 0) begin
          reset = 1'b0;
          apply(16'h0);
        end else begin
          reset = 1'b1;
          v = 16'($urandom);
          v[1] = ($urandom_range(0, 3) != 0);
          v[0] = ($urandom_range(0, 7) < rdy_bias);
          apply(v);
        end
        to_neg();
        to_edge();
      end
      reset = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
